mod_add_arbiter: RTL and testbench

//  Shares one addMod 256-bit modular adder between two requesters (e.g. point-add and point-double FSMs).

---
 rtl/mod_add_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mod_add_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_add_arbiter.sv
// Round-robin arbiter sharing one registered modular adder between two requesters.
// Optional MODADD_SUB_EN adds per-requester subtract select (issues M - b as operand B).
module mod_add_arbiter #(
    parameter int WIDTH   = 256,
    parameter int ADD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] mod_m,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef MODADD_SUB_EN
    input  logic             req0_sub,
`endif
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef MODADD_SUB_EN
    input  logic             req1_sub,
`endif
    output logic [WIDTH-1:0] add_opA,
    output logic [WIDTH-1:0] add_opB,
    output logic [WIDTH-1:0] add_opM,
    input  logic [WIDTH-1:0] add_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LAST = (ADD_LAT > 0) ? 3'(ADD_LAT - 1) : 3'd0;

    state_t           state;
    state_t           state_next;
    logic             last_grant;
    logic [2:0]       cnt;
    logic             grant_any;
    logic             grant_id;
    logic             accept;
    logic             capture;
    logic             cnt_clr;
    logic             cnt_inc;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] issue_b;

    // Round-robin: on a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    accept     = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_clr = 1'b1;
                if (ADD_LAT == 0) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_LAST) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is gated by rst_n so nothing can look accepted while reset is held.
    assign req0_ready = rst_n & accept & ~grant_id;
    assign req1_ready = rst_n & accept & grant_id;
    assign rsp_valid  = (state == S_RESP);
    assign busy       = (state != S_IDLE);

    always_comb begin
        sel_a = grant_id ? req1_a : req0_a;
        sel_b = grant_id ? req1_b : req0_b;
`ifdef MODADD_SUB_EN
        // a - b mod M is formed as a + (M - b); b == 0 yields operand M, result a.
        issue_b = (grant_id ? req1_sub : req0_sub) ? (mod_m - sel_b) : sel_b;
`else
        issue_b = sel_b;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_opA    <= '0;
            add_opB    <= '0;
            add_opM    <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            last_grant <= 1'b1;
            cnt        <= 3'd0;
        end else begin
            if (accept) begin
                add_opA    <= sel_a;
                add_opB    <= issue_b;
                add_opM    <= mod_m;
                rsp_id     <= grant_id;
                last_grant <= grant_id;
            end
            if (cnt_clr) begin
                cnt <= 3'd0;
            end else if (cnt_inc) begin
                cnt <= cnt + 3'd1;
            end
            if (capture) begin
                rsp_data <= add_out;
            end
        end
    end

endmodule

// File: tb/tb_mod_add_arbiter.sv
// Self-checking bench for mod_add_arbiter with a behavioural registered addMod stand-in.
module tb_mod_add_arbiter;
    localparam int W   = 256;
    localparam int LAT = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] mod_m;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
`ifdef MODADD_SUB_EN
    logic         req0_sub = 1'b0;
    logic         req1_sub = 1'b0;
`endif
    logic [W-1:0] add_opA, add_opB, add_opM, add_out;
    logic         rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_add_arbiter #(.WIDTH(W), .ADD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mod_m(mod_m),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
`ifdef MODADD_SUB_EN
        .req0_sub(req0_sub),
`endif
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
`ifdef MODADD_SUB_EN
        .req1_sub(req1_sub),
`endif
        .add_opA(add_opA), .add_opB(add_opB), .add_opM(add_opM), .add_out(add_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy)
    );

    // Registered modular adder: one cycle from operands to result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) add_out <= '0;
        else if (add_opM != '0)
            add_out <= W'(({1'b0, add_opA} + {1'b0, add_opB}) % {1'b0, add_opM});
    end

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [W-1:0] ref_mod(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] m, input bit sub);
        logic [W:0] s;
        if (sub) s = ({1'b0, a} + {1'b0, m} - {1'b0, b}) % {1'b0, m};
        else     s = ({1'b0, a} + {1'b0, b}) % {1'b0, m};
        return s[W-1:0];
    endfunction

    task automatic drive_req(input bit id, input bit v, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit sub);
        if (id == 1'b0) begin
            req0_valid = v; req0_a = a; req0_b = b;
`ifdef MODADD_SUB_EN
            req0_sub = sub;
`endif
        end else begin
            req1_valid = v; req1_a = a; req1_b = b;
`ifdef MODADD_SUB_EN
            req1_sub = sub;
`endif
        end
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chkb({name, "_rsp_timeout"}, rsp_valid, 1'b1);
    endtask

    // Single operation with rsp_ready high: checks issue values, latency, result and hold.
    task automatic run_op(input string name, input bit id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] m, input bit sub,
                          input logic [W-1:0] exp_opb, input logic [W-1:0] exp_data);
        bit got;
        int lat;
        got = 1'b0;
        rsp_ready = 1'b1;
        mod_m = m;
        drive_req(id, 1'b1, a, b, sub);
        #1;
        for (int i = 0; i < 20; i++) begin
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        chkb({name, "_accept"}, got, 1'b1);
        step();
        drive_req(id, 1'b0, ~a, ~b, 1'b0);
        mod_m = ~m;
        chkw({name, "_opA"}, add_opA, a);
        chkw({name, "_opB"}, add_opB, exp_opb);
        chkw({name, "_opM"}, add_opM, m);
        chkb({name, "_busy"}, busy, 1'b1);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chki({name, "_latency"}, lat, LAT + 2);
        chkw({name, "_data"}, rsp_data, exp_data);
        chkb({name, "_id"}, rsp_id, id);
        step();
        chkb({name, "_idle"}, busy, 1'b0);
        chkw({name, "_opA_hold"}, add_opA, a);
        mod_m = m;
    endtask

    typedef struct {
        string        name;
        bit           id;
        logic [W-1:0] a, b, m;
        logic [W-1:0] exp_opb, exp_data;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [W-1:0] ones, half;
        int grants[8];
        int rsps[8];
        logic [W-1:0] rdat[8];
        int ng, nr, n;

        ones = '1;
        half = '0;
        half[W-1] = 1'b1;
        vecs[0] = '{"spec_5p9", 1'b0, W'(5), W'(9), W'(11), W'(9), W'(3)};
        vecs[1] = '{"zeros", 1'b1, W'(0), W'(0), W'(11), W'(0), W'(0)};
        vecs[2] = '{"sum_eq_m", 1'b0, W'(6), W'(5), W'(11), W'(5), W'(0)};
        vecs[3] = '{"max_small", 1'b1, W'(10), W'(10), W'(11), W'(10), W'(9)};
        vecs[4] = '{"max_wide", 1'b0, ones - W'(1), ones - W'(1), ones, ones - W'(1), ones - W'(2)};
        vecs[5] = '{"no_wrap", 1'b1, W'(1), half - W'(2), half, half - W'(2), half - W'(1)};

        // Reset with a requester already valid.
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        mod_m = W'(11);
        drive_req(1'b0, 1'b1, W'(1), W'(2), 1'b0);
        drive_req(1'b1, 1'b0, W'(0), W'(0), 1'b0);
        repeat (3) step();
        #1;
        chkb("rst_req0_ready", req0_ready, 1'b0);
        chkb("rst_rsp_valid", rsp_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkw("rst_opA", add_opA, '0);
        chkw("rst_opB", add_opB, '0);
        chkw("rst_opM", add_opM, '0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Contention: both requesters valid, grants must alternate starting with 0.
        drive_req(1'b0, 1'b1, W'(1), W'(2), 1'b0);
        drive_req(1'b1, 1'b1, W'(4), W'(5), 1'b0);
        ng = 0;
        nr = 0;
        for (int i = 0; i < 8; i++) begin grants[i] = -1; rsps[i] = -1; rdat[i] = '0; end
        for (int c = 0; c < 60 && nr < 4; c++) begin
            #1;
            chkb("cont_both_ready", req0_ready & req1_ready, 1'b0);
            if ((req0_ready || req1_ready) && ng < 8) begin grants[ng] = int'(req1_ready); ng++; end
            if (rsp_valid) begin rsps[nr] = int'(rsp_id); rdat[nr] = rsp_data; nr++; end
            if (nr < 4) step();
        end
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            chki("cont_grant", grants[i], i % 2);
            chki("cont_rsp_id", rsps[i], i % 2);
            chkw("cont_rsp_data", rdat[i], (i % 2 == 0) ? W'(3) : W'(9));
        end

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].name, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].m, 1'b0,
                   vecs[i].exp_opb, vecs[i].exp_data);

        // Backpressure: response held, competing request blocked until the handshake.
        rsp_ready = 1'b0;
        mod_m = W'(11);
        drive_req(1'b0, 1'b1, W'(2), W'(3), 1'b0);
        #1;
        n = 0;
        while (!req0_ready && n < 20) begin step(); n++; end
        chkb("bp_accept", req0_ready, 1'b1);
        step();
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        wait_rsp("bp");
        drive_req(1'b1, 1'b1, W'(7), W'(8), 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            chkb("bp_valid", rsp_valid, 1'b1);
            chkw("bp_data", rsp_data, W'(5));
            chkb("bp_id", rsp_id, 1'b0);
            chkb("bp_req1_ready", req1_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chkb("bp_req1_ready_hs", req1_ready, 1'b0);
        step();
        chkb("bp_req1_next", req1_ready, 1'b1);
        step();
        drive_req(1'b1, 1'b0, '0, '0, 1'b0);
        wait_rsp("bp2");
        chkw("bp2_data", rsp_data, W'(4));
        chkb("bp2_id", rsp_id, 1'b1);
        step();

        // Reset while waiting on the adder.
        drive_req(1'b0, 1'b1, W'(1), W'(1), 1'b0);
        #1;
        chkb("mid_accept", req0_ready, 1'b1);
        step();
        drive_req(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        chkb("mid_busy_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chkb("mid_busy", busy, 1'b0);
        chkb("mid_rsp_valid", rsp_valid, 1'b0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chkb("mid_no_rsp", rsp_valid | busy, 1'b0);
            step();
        end
        run_op("after_rst", 1'b0, W'(7), W'(8), W'(11), 1'b0, W'(8), W'(4));

        // Randomized traffic against a transaction-level model.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int seg = 0; seg < 4; seg++) begin
            logic [W-1:0] m, a0, b0, a1, b1, exp_data;
            bit hold0, hold1, outstanding, last, exp_id, er0, er1, erv;
            int cyc, acc_cyc;
            m = (seg % 2 == 0) ? (rnd_w() | W'(1)) : W'($urandom_range(2, 300));
            mod_m = m;
            hold0 = 0; hold1 = 0; outstanding = 0; exp_id = 0; cyc = 0; acc_cyc = 0;
            last = (seg == 0) ? 1'b1 : last;
            a0 = '0; b0 = '0; a1 = '0; b1 = '0; exp_data = '0;
            if (seg == 0) last = 1'b1;
            for (int c = 0; c < 400; c++) begin
                if (!hold0) begin
                    if ($urandom % 3 == 0) begin hold0 = 1; a0 = rnd_w() % m; b0 = rnd_w() % m; end
                end else if ($urandom % 16 == 0) hold0 = 0;
                if (!hold1) begin
                    if ($urandom % 3 == 0) begin hold1 = 1; a1 = rnd_w() % m; b1 = rnd_w() % m; end
                end else if ($urandom % 16 == 0) hold1 = 0;
                drive_req(1'b0, hold0, a0, b0, 1'b0);
                drive_req(1'b1, hold1, a1, b1, 1'b0);
                rsp_ready = ($urandom % 4 != 0);
                #1;
                er0 = !outstanding && hold0 && (!hold1 || last);
                er1 = !outstanding && hold1 && (!hold0 || !last);
                erv = outstanding && (cyc - acc_cyc >= LAT + 2);
                chkb("rnd_ready0", req0_ready, er0);
                chkb("rnd_ready1", req1_ready, er1);
                chkb("rnd_rsp_valid", rsp_valid, erv);
                chkb("rnd_busy", busy, outstanding);
                if (erv && rsp_valid) begin
                    chkb("rnd_rsp_id", rsp_id, exp_id);
                    chkw("rnd_rsp_data", rsp_data, exp_data);
                end
                if (erv && rsp_ready) outstanding = 0;
                if (er0 || er1) begin
                    outstanding = 1;
                    acc_cyc = cyc;
                    exp_id = er1;
                    last = er1;
                    exp_data = er1 ? ref_mod(a1, b1, m, 1'b0) : ref_mod(a0, b0, m, 1'b0);
                    if (er1) hold1 = 0; else hold0 = 0;
                end
                cyc++;
                step();
            end
            drive_req(1'b0, 1'b0, '0, '0, 1'b0);
            drive_req(1'b1, 1'b0, '0, '0, 1'b0);
            rsp_ready = 1'b1;
            n = 0;
            while (busy && n < 20) begin step(); n++; end
            chkb("rnd_drain", busy, 1'b0);
        end

`ifdef MODADD_SUB_EN
        run_op("sub_3m7", 1'b1, W'(3), W'(7), W'(11), 1'b1, W'(4), W'(7));
        run_op("sub_b0", 1'b1, W'(6), W'(0), W'(11), 1'b1, W'(11), W'(6));
        run_op("nosub_r1", 1'b1, W'(3), W'(7), W'(11), 1'b0, W'(7), W'(10));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
